// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the halt/dump run-control block: FSM states and
// the halt instruction / word size constants.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DRAIN = 3'd1,
    ST_RD    = 3'd2,
    ST_CAP   = 3'd3,
    ST_OUT   = 3'd4,
    ST_DONE  = 3'd5,
    ST_TOUT  = 3'd6
  } state_t;

  localparam logic [31:0] HALT_INST  = 32'h0;
  localparam int          WORD_BYTES = 4;

endpackage

// File: rtl/halt_dump_controller_if.sv
// Signal bundle between the run-control block (master) and the SoC/bench
// side (slave): fetch observation, DMEM dump read port, dump stream, status.
interface halt_dump_controller_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic [31:0]       inst_i;
  logic              inst_valid_i;
  logic              dmem_rd_en_o;
  logic [ADDR_W-1:0] dmem_rd_addr_o;
  logic [31:0]       dmem_rd_data_i;
  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [ADDR_W-1:0] dump_addr_o;
  logic [31:0]       dump_data_o;
  logic              core_halt_o;
  logic [CNT_W-1:0]  cycles_o;
  logic              halted_o;
  logic              timeout_o;
  logic              done_o;

  modport master (
    input  inst_i, inst_valid_i, dmem_rd_data_i, dump_ready_i,
    output dmem_rd_en_o, dmem_rd_addr_o, dump_valid_o, dump_addr_o,
           dump_data_o, core_halt_o, cycles_o, halted_o, timeout_o, done_o
  );

  modport slave (
    output inst_i, inst_valid_i, dmem_rd_data_i, dump_ready_i,
    input  dmem_rd_en_o, dmem_rd_addr_o, dump_valid_o, dump_addr_o,
           dump_data_o, core_halt_o, cycles_o, halted_o, timeout_o, done_o
  );

endinterface

// File: rtl/halt_dump_controller_watchdog.sv
// Saturating run-cycle counter with a timeout compare; counting stops once
// the limit is reached so the reported count equals the limit.
module cycle_watchdog #(
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             freeze,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  assign expired = (count == LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en && !freeze && !expired && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/halt_dump_controller.sv
// Run-control FSM: counts RUN cycles, detects the halt fetch, drains the
// pipeline, then streams DUMP_WORDS DMEM words out; a watchdog ends runaways.
module halt_dump_controller
  import run_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int CNT_W          = 32,
  parameter int DRAIN_CYCLES   = 5,
  parameter int DUMP_WORDS     = 8,
  parameter int TIMEOUT_CYCLES = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  halt_dump_controller_if.master bus,
  output state_t                 dbg_state
);

  localparam int IDX_W = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
  localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DUMP_WORDS - 1);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  if (DUMP_WORDS < 1) begin : g_bad_dump_words
    $error("halt_dump_controller: DUMP_WORDS must be at least 1");
  end

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [DRN_W-1:0]  drain_cnt, drain_nx;
  logic              halted;
  logic [ADDR_W-1:0] dump_addr_q;
  logic [31:0]       dump_data_q;
  logic [ADDR_W-1:0] word_addr;
  logic              halt_det;
  logic              expired;

  assign halt_det  = (state == ST_RUN) && bus.inst_valid_i && (bus.inst_i == HALT_INST);
  assign word_addr = ADDR_W'(idx) * ADDR_W'(WORD_BYTES);

  cycle_watchdog #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .en      (state == ST_RUN),
    .freeze  (halt_det),
    .count   (bus.cycles_o),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      idx         <= '0;
      drain_cnt   <= '0;
      halted      <= 1'b0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      drain_cnt <= drain_nx;
      if (halt_det) halted <= 1'b1;
      if (state == ST_CAP) begin
        dump_addr_q <= word_addr;
        dump_data_q <= bus.dmem_rd_data_i;
      end
    end
  end

  // Halt is checked before the watchdog so a halt on the limit cycle wins.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    drain_nx = drain_cnt;
    case (state)
      ST_RUN: begin
        if (halt_det) begin
          drain_nx = '0;
          state_nx = (DRAIN_CYCLES > 0) ? ST_DRAIN : ST_RD;
        end else if (expired) begin
          state_nx = ST_TOUT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nx = ST_RD;
        else                         drain_nx = drain_cnt + DRN_W'(1);
      end
      ST_RD:  state_nx = ST_CAP;
      ST_CAP: state_nx = ST_OUT;
      ST_OUT: begin
        if (bus.dump_ready_i) begin
          if (idx == LAST_IDX) begin
            state_nx = ST_DONE;
          end else begin
            idx_nx   = idx + IDX_W'(1);
            state_nx = ST_RD;
          end
        end
      end
      ST_DONE: state_nx = ST_DONE;
      ST_TOUT: state_nx = ST_TOUT;
      default: state_nx = ST_RUN;
    endcase
  end

  // Dump stream: a beat transfers on a rising edge where dump_valid_o and
  // dump_ready_i are both high; valid never drops and addr/data never change
  // while a beat is waiting for ready.
  assign bus.dmem_rd_en_o   = (state == ST_RD);
  assign bus.dmem_rd_addr_o = word_addr;
  assign bus.dump_valid_o   = (state == ST_OUT);
  assign bus.dump_addr_o    = dump_addr_q;
  assign bus.dump_data_o    = dump_data_q;
  assign bus.core_halt_o    = (state == ST_RD) || (state == ST_CAP) || (state == ST_OUT) ||
                              (state == ST_DONE) || (state == ST_TOUT);
  assign bus.halted_o       = halted;
  assign bus.timeout_o      = (state == ST_TOUT);
  assign bus.done_o         = (state == ST_DONE) || (state == ST_TOUT);
  assign dbg_state          = state;

endmodule

// File: tb/tb_halt_dump_controller.sv
// Bench for halt_dump_controller: DMEM model, dump-stream scoreboard, and
// directed halt/backpressure/timeout/reset scenarios on two DRAIN builds.
module tb_halt_dump_controller;
  import run_ctrl_pkg::*;

  localparam int AW = 32;
  localparam int CW = 32;
  localparam int NW = 8;
  localparam int TO = 100;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  halt_dump_controller_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();
  halt_dump_controller_if #(.ADDR_W(AW), .CNT_W(CW)) bus0 ();
  state_t st, st0;

  halt_dump_controller #(
    .ADDR_W(AW), .CNT_W(CW), .DRAIN_CYCLES(5), .DUMP_WORDS(NW), .TIMEOUT_CYCLES(TO)
  ) dut (.clk(clk), .reset(reset), .bus(bus), .dbg_state(st));

  halt_dump_controller #(
    .ADDR_W(AW), .CNT_W(CW), .DRAIN_CYCLES(0), .DUMP_WORDS(NW), .TIMEOUT_CYCLES(TO)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0), .dbg_state(st0));

  logic [31:0] mem [NW];
  always @(posedge clk) begin
    if (bus.dmem_rd_en_o)  bus.dmem_rd_data_i  <= mem[bus.dmem_rd_addr_o[4:2]];
    if (bus0.dmem_rd_en_o) bus0.dmem_rd_data_i <= mem[bus0.dmem_rd_addr_o[4:2]];
  end

  logic [63:0] exp_q[$];
  logic [63:0] exp0_q[$];
  int total = 0;
  int bad   = 0;
  int beats, beats0, rd_seen, cyc, last_hs;
  bit gap_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_dump(input bit which);
    logic [63:0] w;
    for (int i = 0; i < NW; i++) begin
      w = {32'(i * 4), 32'h11111111 * 32'(i + 1)};
      if (which) exp0_q.push_back(w);
      else       exp_q.push_back(w);
    end
  endtask

  // Called at a negedge after inputs are set: scores what the next posedge sees.
  task automatic step();
    logic [63:0] e;
    if (bus.dump_valid_o && bus.dump_ready_i) begin
      check("q_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", {bus.dump_addr_o, bus.dump_data_o}, e);
      end
      if (gap_chk && beats > 0) check("beat_gap", 64'(cyc - last_hs), 64'd3);
      last_hs = cyc;
      beats++;
    end
    if (bus0.dump_valid_o && bus0.dump_ready_i) begin
      check("q0_nonempty", 64'(exp0_q.size() != 0), 64'd1);
      if (exp0_q.size() != 0) begin
        e = exp0_q.pop_front();
        check("beat0", {bus0.dump_addr_o, bus0.dump_data_o}, e);
      end
      beats0++;
    end
    if (bus.dmem_rd_en_o) rd_seen++;
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 64'({bus.dmem_rd_en_o, bus.dump_valid_o, bus.core_halt_o,
                                bus.halted_o, bus.timeout_o, bus.done_o}), 64'd0);
    check({tag, "_cycles"}, 64'(bus.cycles_o), 64'd0);
    check({tag, "_addr"}, {bus.dmem_rd_addr_o, bus.dump_addr_o}, 64'd0);
    check({tag, "_data"}, 64'(bus.dump_data_o), 64'd0);
    check({tag, "_state"}, 64'(st), 64'(ST_RUN));
    check({tag, "_flags0"}, 64'({bus0.dmem_rd_en_o, bus0.dump_valid_o, bus0.core_halt_o,
                                 bus0.halted_o, bus0.timeout_o, bus0.done_o}), 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    bus.inst_i  = 32'h00000013; bus.inst_valid_i  = 1'b1; bus.dump_ready_i  = 1'b1;
    bus0.inst_i = 32'h00000013; bus0.inst_valid_i = 1'b1; bus0.dump_ready_i = 1'b1;
    #1;
    check_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    beats = 0; beats0 = 0; rd_seen = 0; gap_chk = 1'b0;
    exp_q.delete(); exp0_q.delete();
  endtask

  task automatic halt_at(input int n);
    int guard = 0;
    while (bus.cycles_o != CW'(n) && guard < 300) begin step(); guard++; end
    check("halt_wait", 64'(bus.cycles_o), 64'(n));
    bus.inst_i = 32'h0; bus.inst_valid_i = 1'b1;
    push_dump(1'b0);
    step();
    bus.inst_i = 32'h00000013;
    check("halted", 64'(bus.halted_o), 64'd1);
    check("cycles_hold", 64'(bus.cycles_o), 64'(n));
  endtask

  task automatic run_until_done(input int n);
    int guard = 0;
    while (beats < n && guard < 300) begin
      if (beats == n - 1 && bus.dump_valid_o && bus.dump_ready_i)
        check("done_before_last", 64'(bus.done_o), 64'd0);
      step();
      guard++;
    end
    check("beat_count", 64'(beats), 64'(n));
    check("done_after_last", 64'(bus.done_o), 64'd1);
    check("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time limit hit");
    $fatal(1, "bench stalled");
  end

  initial begin
    int lat, stall, guard;
    for (int i = 0; i < NW; i++) mem[i] = 32'h11111111 * 32'(i + 1);
    cyc = 0; last_hs = 0;

    // Normal halt at cycle 10 with ready always high
    reset_dut();
    halt_at(10);
    gap_chk = 1'b1;
    check("drain_state", 64'(st), 64'(ST_DRAIN));
    check("drain_core_run", 64'(bus.core_halt_o), 64'd0);
    lat = 0;
    while (!bus.dmem_rd_en_o && lat < 20) begin step(); lat++; end
    check("rd_latency", 64'(lat), 64'd5);
    check("rd_core_halt", 64'(bus.core_halt_o), 64'd1);
    run_until_done(NW);
    check("done_no_tout", 64'(bus.timeout_o), 64'd0);

    // Backpressure on the 0x0C beat
    reset_dut();
    halt_at(4);
    stall = 0; guard = 0;
    while (beats < NW && guard < 300) begin
      if (bus.dump_valid_o && bus.dump_addr_o == 32'h0C && stall < 4) begin
        bus.dump_ready_i = 1'b0;
        check("bp_hold", {bus.dump_addr_o, bus.dump_data_o}, {32'h0000000C, 32'h44444444});
        stall++;
      end else begin
        bus.dump_ready_i = 1'b1;
      end
      step();
      guard++;
    end
    check("bp_stalls", 64'(stall), 64'd4);
    check("bp_beats", 64'(beats), 64'(NW));
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);
    check("bp_done", 64'(bus.done_o), 64'd1);

    // No halt: watchdog fires
    reset_dut();
    guard = 0;
    while (!bus.done_o && guard < 300) begin step(); guard++; end
    check("to_flags", 64'({bus.timeout_o, bus.done_o, bus.halted_o, bus.dump_valid_o, bus.core_halt_o}),
          64'b11001);
    check("to_cycles", 64'(bus.cycles_o), 64'(TO));
    check("to_no_rd", 64'(rd_seen), 64'd0);
    check("to_state", 64'(st), 64'(ST_TOUT));

    // Halt exactly on the timeout cycle: halt wins
    reset_dut();
    halt_at(TO);
    check("edge_no_tout", 64'(bus.timeout_o), 64'd0);
    run_until_done(NW);
    check("edge_tout_final", 64'(bus.timeout_o), 64'd0);

    // Reset during the 0x10 beat, then full rerun
    reset_dut();
    halt_at(3);
    guard = 0;
    while (!(beats == 4 && bus.dump_valid_o) && guard < 300) begin step(); guard++; end
    check("mid_addr", 64'(bus.dump_addr_o), 64'h10);
    #2 reset = 1'b0;
    #1 check_zero("mid_rst");
    exp_q.delete(); exp0_q.delete();
    @(negedge clk);
    reset = 1'b1;
    beats = 0; beats0 = 0;
    halt_at(3);
    run_until_done(NW);

    // DRAIN_CYCLES=0 build: unqualified zero ignored, halt goes straight to RD
    reset_dut();
    bus0.inst_i = 32'h0; bus0.inst_valid_i = 1'b0;
    guard = 0;
    while (bus0.cycles_o != CW'(5) && guard < 50) begin step(); guard++; end
    check("z_count_runs", 64'(guard), 64'd5);
    check("z_not_halted", 64'(bus0.halted_o), 64'd0);
    bus0.inst_valid_i = 1'b1;
    push_dump(1'b1);
    step();
    bus0.inst_valid_i = 1'b0;
    check("z_rd_now", 64'({bus0.dmem_rd_en_o, bus0.halted_o, bus0.core_halt_o}), 64'b111);
    check("z_cycles", 64'(bus0.cycles_o), 64'd5);
    guard = 0;
    while (beats0 < NW && guard < 100) begin step(); guard++; end
    check("z_beats", 64'(beats0), 64'(NW));
    check("z_done", 64'(bus0.done_o), 64'd1);
    check("z_q_empty", 64'(exp0_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
